pcm_uart_framer: RTL and testbench

Sits between the CIC3 PDM decimator and the UART transmitter in the microphone design. Buffers 16-bit PCM samples in a small FIFO, wraps each one in a 4-byte frame (sync byte, MSB, LSB, XOR check byte), and feeds the frame byte-by-byte to the UART transmitter over its go/ready handshake. Records samples dropped because the UART link cannot keep up.

---
 rtl/pcm_framer_pkg.sv | 13 +
 rtl/sync_sample_fifo.sv | 36 +++
 rtl/pcm_uart_framer.sv | 77 +++++++
 tb/tb_pcm_uart_framer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pcm_framer_pkg.sv
// pcm_framer_pkg: shared FSM states, frame layout constants and byte selection for the PCM UART framer.
package pcm_framer_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  localparam int FRAME_LEN = 4;
  localparam logic [1:0] IDX_SYNC = 2'd0;
  localparam logic [1:0] IDX_MSB = 2'd1;
  localparam logic [1:0] IDX_LSB = 2'd2;
  localparam logic [1:0] IDX_LAST = 2'(FRAME_LEN - 1);
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] s, input logic [7:0] sync);
    return idx == IDX_SYNC ? sync : idx == IDX_MSB ? s[15:8] : idx == IDX_LSB ? s[7:0] : s[15:8] ^ s[7:0];
  endfunction
endpackage

// File: rtl/sync_sample_fifo.sv
// sync_sample_fifo: 16-bit synchronous FIFO; a push while full is accepted only when a pop frees a slot.
module sync_sample_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [15:0]   din,
  input  logic          pop,
  output logic [15:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic wen;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign wen = push & (~full | pop);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (wen) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      wr <= wr + AW'(wen);
      rd <= rd + AW'(pop);
      level <= level + (AW+1)'(wen) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/pcm_uart_framer.sv
// pcm_uart_framer: buffers PCM samples and sends each as a 4-byte sync/MSB/LSB/XOR frame over a go/ready UART handshake.
module pcm_uart_framer
  import pcm_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   pcm,
  input  logic                          pcm_valid,
  input  logic                          uart_ready,
  output logic [7:0]                    char,
  output logic                          uart_go,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count
);
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] char_n;
  logic go_n, pop, full, empty, drop;
  logic [15:0] head, shadow;
  sync_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(pcm_valid), .din(pcm), .pop(pop),
    .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  assign drop = pcm_valid & full & ~pop;
  assign busy = (state != IDLE) | (fifo_level != '0);
  always_comb begin
    state_n = state;
    idx_n = idx;
    char_n = char;
    go_n = uart_go;
    pop = 1'b0;
    case (state)
      IDLE: if (~empty & uart_ready) begin
        pop = 1'b1;
        state_n = SEND;
        idx_n = IDX_SYNC;
        char_n = SYNC_BYTE;
        go_n = 1'b1;
      end
      SEND: if (~uart_ready) begin
        go_n = 1'b0;
        state_n = WAIT;
      end
      default: if (uart_ready) begin
        state_n = idx == IDX_LAST ? IDLE : SEND;
        idx_n = idx == IDX_LAST ? idx : idx + 2'd1;
        char_n = idx == IDX_LAST ? char : frame_byte(idx + 2'd1, shadow, SYNC_BYTE);
        go_n = idx != IDX_LAST;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= IDX_SYNC;
      char <= '0;
      uart_go <= 1'b0;
      shadow <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      char <= char_n;
      uart_go <= go_n;
      if (pop) shadow <= head;
      if (drop) overflow <= 1'b1;
      if (drop & ~&drop_count) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pcm_uart_framer.sv
// tb_pcm_uart_framer: directed frame table plus hand-written FIFO, overflow, handshake and reset sequences.
module tb_pcm_uart_framer;
  logic clk = 0, rst = 1;
  logic [15:0] pcm = '0;
  logic pcm_valid = 0;
  logic uart_ready;
  logic [7:0] char;
  logic uart_go, busy, overflow;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;
  logic model_en = 0, model_ready = 1, man_ready = 0;
  int model_cnt = 0;
  logic [7:0] cap [$];
  int n_cmp = 0, n_bad = 0;
  logic prev_go = 0;
  logic [7:0] prev_char = '0;

  typedef struct {
    logic [15:0] pcm;
    logic [7:0] b1, b2, b3;
  } vec_t;
  vec_t tbl [9];

  assign uart_ready = model_en ? model_ready : man_ready;
  always #5 clk = ~clk;

  pcm_uart_framer #(.SYNC_BYTE(8'hA5), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pcm(pcm), .pcm_valid(pcm_valid), .uart_ready(uart_ready),
    .char(char), .uart_go(uart_go), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  // Behavioural transmitter: takes the byte one cycle after go, stays busy ~40 cycles.
  always @(posedge clk) begin
    if (model_en && model_ready && uart_go) begin
      cap.push_back(char);
      model_ready <= 1'b0;
      model_cnt <= 40;
    end else if (!model_ready) begin
      if (model_cnt <= 1) model_ready <= 1'b1;
      model_cnt <= model_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_go && uart_go) chk("char_stable", char, prev_char);
    prev_go = uart_go;
    prev_char = char;
  end

  task automatic wait_bytes(input int n);
    int t = 0;
    while (cap.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (cap.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_bytes: got %0d bytes expected %0d", cap.size(), n);
    end
  endtask

  task automatic check_frame(input int r);
    logic [7:0] e [4];
    logic [7:0] b;
    e = '{8'hA5, tbl[r].b1, tbl[r].b2, tbl[r].b3};
    wait_bytes(4);
    for (int k = 0; k < 4; k++) begin
      b = cap.size() > 0 ? cap.pop_front() : 8'hxx;
      chk($sformatf("frame%0d_byte%0d", r, k), b, e[k]);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("busy_idle", busy, 0);
  endtask

  task automatic pulse(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pcm = base + 16'(i);
      pcm_valid = 1;
    end
    @(negedge clk);
    pcm_valid = 0;
  endtask

  task automatic send_frame(input int r);
    @(negedge clk);
    pcm = tbl[r].pcm;
    pcm_valid = 1;
    @(negedge clk);
    pcm_valid = 0;
    @(negedge clk);
    chk("latency_go", uart_go, 1);
    chk("latency_char", char, 8'hA5);
    check_frame(r);
    wait_idle();
  endtask

  initial begin
    int t;
    tbl[0] = '{16'h12F0, 8'h12, 8'hF0, 8'hE2};
    tbl[1] = '{16'h0001, 8'h00, 8'h01, 8'h01};
    tbl[2] = '{16'h0002, 8'h00, 8'h02, 8'h02};
    tbl[3] = '{16'h0003, 8'h00, 8'h03, 8'h03};
    tbl[4] = '{16'h0004, 8'h00, 8'h04, 8'h04};
    tbl[5] = '{16'h0005, 8'h00, 8'h05, 8'h05};
    tbl[6] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00};
    tbl[7] = '{16'hA55A, 8'hA5, 8'h5A, 8'hFF};
    tbl[8] = '{16'h9A3C, 8'h9A, 8'h3C, 8'hA6};

    repeat (2) @(negedge clk);
    chk("rst_char", char, 0);
    chk("rst_go", uart_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    rst = 0;

    model_en = 1;
    send_frame(0);
    send_frame(6);
    send_frame(7);

    model_en = 0;
    man_ready = 0;
    pulse(4, 16'h0001);
    chk("fill_level", fifo_level, 4);
    chk("fill_overflow", overflow, 0);
    chk("fill_drop", drop_count, 0);
    chk("fill_busy", busy, 1);
    chk("fill_go", uart_go, 0);

    @(negedge clk);
    man_ready = 1;
    pcm = 16'h0005;
    pcm_valid = 1;
    @(negedge clk);
    pcm_valid = 0;
    chk("simul_level", fifo_level, 4);
    chk("simul_drop", drop_count, 0);
    chk("simul_overflow", overflow, 0);
    chk("simul_go", uart_go, 1);
    chk("simul_char", char, 8'hA5);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_go", uart_go, 1);
      chk("hold_char", char, 8'hA5);
    end
    man_ready = 0;
    cap.push_back(8'hA5);
    @(negedge clk);
    chk("release_go", uart_go, 0);

    pulse(3, 16'hDEAD);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop3", drop_count, 3);
    chk("ovf_level", fifo_level, 4);
    pulse(252, 16'h0000);
    chk("ovf_drop255", drop_count, 255);
    pulse(1, 16'h0000);
    chk("ovf_sat", drop_count, 255);
    chk("ovf_level2", fifo_level, 4);

    model_en = 1;
    for (int r = 1; r <= 5; r++) check_frame(r);
    wait_idle();

    @(negedge clk);
    pcm = 16'h1234;
    pcm_valid = 1;
    @(negedge clk);
    pcm = 16'h5678;
    @(negedge clk);
    pcm_valid = 0;
    wait_bytes(2);
    chk("pre_rst_level", fifo_level, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_go", uart_go, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_drop", drop_count, 0);
    chk("midrst_busy", busy, 0);
    cap.delete();
    t = 0;
    while (!model_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("model_ready", model_ready, 1);
    send_frame(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
